// File: rtl/sysop_pkg.sv
// rtl/sysop_pkg.sv - shared cause codes, state type and trap-class helper for the system-op sequencer
package sysop_pkg;

    localparam logic [4:0] SYSOP_NONE    = 5'd0;
    localparam logic [4:0] SYSOP_ECALL   = 5'd1;
    localparam logic [4:0] SYSOP_EBREAK  = 5'd2;
    localparam logic [4:0] SYSOP_RET     = 5'd3;
    localparam logic [4:0] SYSOP_RET_S   = 5'd4;
    localparam logic [4:0] SYSOP_CSR_W   = 5'd5;
    localparam logic [4:0] SYSOP_CSR_S   = 5'd6;
    localparam logic [4:0] SYSOP_CSR_C   = 5'd7;
    localparam logic [4:0] SYSOP_ILLEGAL = 5'd8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HOLD  = 2'd1,
        FLUSH = 2'd2
    } state_t;

    // Trap-class causes redirect the pipeline and therefore need a flush window.
    function automatic logic is_trap_cause(input logic [4:0] cause);
        return (cause == SYSOP_ILLEGAL) || (cause == SYSOP_ECALL) ||
               (cause == SYSOP_EBREAK)  || (cause == SYSOP_RET)   ||
               (cause == SYSOP_RET_S);
    endfunction

endpackage

// File: rtl/sysop_prio_enc.sv
// rtl/sysop_prio_enc.sv - combinational priority encoder from op strobes to cause, tval and multi-strobe flag
module sysop_prio_enc
    import sysop_pkg::*;
#(
    parameter int XLEN    = 64,
    parameter bit SRET_EN = 1'b1
) (
    input  logic            ecall_op,
    input  logic            ebreak_op,
    input  logic            mret_op,
    input  logic            sret_op,
    input  logic            csrrw_op,
    input  logic            csrrs_op,
    input  logic            csrrc_op,
    input  logic            illegal_op,
    input  logic [11:0]     csr_addr,
    input  logic [31:0]     insn,
    input  logic [XLEN-1:0] pc,
    output logic [4:0]      cause,
    output logic [XLEN-1:0] tval,
    output logic            multi_err
);

    logic       sret_legal;
    logic       illegal_eff;
    logic [7:0] strobes;

    // An sret on a core without supervisor mode is folded into the illegal class.
    assign sret_legal  = sret_op & SRET_EN;
    assign illegal_eff = illegal_op | (sret_op & ~SRET_EN);
    assign strobes     = {illegal_op, ecall_op, ebreak_op, mret_op,
                          sret_op, csrrw_op, csrrs_op, csrrc_op};
    assign multi_err   = ($countones(strobes) > 1);

    // Highest-priority strobe wins; tval source follows the winning cause.
    always_comb begin
        cause = SYSOP_NONE;
        tval  = '0;
        if (illegal_eff) begin
            cause = SYSOP_ILLEGAL;
            tval  = {{(XLEN-32){1'b0}}, insn};
        end else if (ecall_op) begin
            cause = SYSOP_ECALL;
        end else if (ebreak_op) begin
            cause = SYSOP_EBREAK;
            tval  = pc;
        end else if (mret_op) begin
            cause = SYSOP_RET;
        end else if (sret_legal) begin
            cause = SYSOP_RET_S;
        end else if (csrrw_op) begin
            cause = SYSOP_CSR_W;
            tval  = {{(XLEN-12){1'b0}}, csr_addr};
        end else if (csrrs_op) begin
            cause = SYSOP_CSR_S;
            tval  = {{(XLEN-12){1'b0}}, csr_addr};
        end else if (csrrc_op) begin
            cause = SYSOP_CSR_C;
            tval  = {{(XLEN-12){1'b0}}, csr_addr};
        end
    end

endmodule

// File: rtl/sysop_trap_seq.sv
// rtl/sysop_trap_seq.sv - registered system-op capture with commit handshake and timed flush sequence
module sysop_trap_seq
    import sysop_pkg::*;
#(
    parameter int XLEN         = 64,
    parameter int FLUSH_CYCLES = 2,
    parameter bit SRET_EN      = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            ecall_op,
    input  logic            ebreak_op,
    input  logic            mret_op,
    input  logic            sret_op,
    input  logic            csrrw_op,
    input  logic            csrrs_op,
    input  logic            csrrc_op,
    input  logic            illegal_op,
    input  logic [11:0]     csr_addr,
    input  logic [31:0]     insn,
    input  logic [XLEN-1:0] pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [4:0]      e_cause,
    output logic [XLEN-1:0] e_tval,
    output logic [XLEN-1:0] e_pc,
    output logic            multi_err,
    output logic            flush,
    output logic            busy
);

    localparam int             CNT_W      = $clog2(FLUSH_CYCLES + 1);
    localparam logic [CNT_W-1:0] FLUSH_LOAD = CNT_W'(FLUSH_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(1);

    state_t            state;
    state_t            state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic              any_op;
    logic              capture;
    logic              enter_idle;
    logic [4:0]        enc_cause;
    logic [XLEN-1:0]   enc_tval;
    logic              enc_multi;

    sysop_prio_enc #(
        .XLEN    (XLEN),
        .SRET_EN (SRET_EN)
    ) u_prio_enc (
        .ecall_op   (ecall_op),
        .ebreak_op  (ebreak_op),
        .mret_op    (mret_op),
        .sret_op    (sret_op),
        .csrrw_op   (csrrw_op),
        .csrrs_op   (csrrs_op),
        .csrrc_op   (csrrc_op),
        .illegal_op (illegal_op),
        .csr_addr   (csr_addr),
        .insn       (insn),
        .pc         (pc),
        .cause      (enc_cause),
        .tval       (enc_tval),
        .multi_err  (enc_multi)
    );

    assign any_op     = ecall_op | ebreak_op | mret_op | sret_op |
                        csrrw_op | csrrs_op | csrrc_op | illegal_op;
    assign capture    = (state == IDLE) && in_valid && any_op;
    assign enter_idle = (state != IDLE) && (state_nxt == IDLE);

    // State register; reset forces IDLE so status outputs drop at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state selection and state-decoded handshake/status outputs.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        flush     = 1'b0;
        busy      = 1'b1;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (capture) begin
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = is_trap_cause(e_cause) ? FLUSH : IDLE;
                end
            end
            FLUSH: begin
                flush = 1'b1;
                if (cnt == CNT_LAST) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Flush timer: loaded on commit of a trap op, counts down while flushing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if ((state == HOLD) && out_ready && is_trap_cause(e_cause)) begin
            cnt <= FLUSH_LOAD;
        end else if (state == FLUSH) begin
            cnt <= cnt - CNT_LAST;
        end else begin
            cnt <= '0;
        end
    end

    // Result registers: loaded on capture, held through HOLD/FLUSH, cleared on return to IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            e_cause   <= SYSOP_NONE;
            e_tval    <= '0;
            e_pc      <= '0;
            multi_err <= 1'b0;
        end else if (capture) begin
            e_cause   <= enc_cause;
            e_tval    <= enc_tval;
            e_pc      <= pc;
            multi_err <= enc_multi;
        end else if (enter_idle) begin
            e_cause   <= SYSOP_NONE;
            e_tval    <= '0;
            e_pc      <= '0;
            multi_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sysop_trap_seq.sv
// tb/tb_sysop_trap_seq.sv - self-checking bench for sysop_trap_seq with SRET_EN=1 and SRET_EN=0 instances
module tb_sysop_trap_seq;

    localparam int XLEN = 64;
    localparam int FC   = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            ecall_op, ebreak_op, mret_op, sret_op;
    logic            csrrw_op, csrrs_op, csrrc_op, illegal_op;
    logic [11:0]     csr_addr;
    logic [31:0]     insn;
    logic [XLEN-1:0] pc;
    logic            out_ready;

    logic            in_ready_w  [2];
    logic            out_valid_w [2];
    logic [4:0]      e_cause_w   [2];
    logic [XLEN-1:0] e_tval_w    [2];
    logic [XLEN-1:0] e_pc_w      [2];
    logic            multi_w     [2];
    logic            flush_w     [2];
    logic            busy_w      [2];

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    sysop_trap_seq #(.XLEN(XLEN), .FLUSH_CYCLES(FC), .SRET_EN(1'b1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w[1]),
        .ecall_op(ecall_op), .ebreak_op(ebreak_op), .mret_op(mret_op), .sret_op(sret_op),
        .csrrw_op(csrrw_op), .csrrs_op(csrrs_op), .csrrc_op(csrrc_op), .illegal_op(illegal_op),
        .csr_addr(csr_addr), .insn(insn), .pc(pc),
        .out_valid(out_valid_w[1]), .out_ready(out_ready),
        .e_cause(e_cause_w[1]), .e_tval(e_tval_w[1]), .e_pc(e_pc_w[1]),
        .multi_err(multi_w[1]), .flush(flush_w[1]), .busy(busy_w[1])
    );

    sysop_trap_seq #(.XLEN(XLEN), .FLUSH_CYCLES(FC), .SRET_EN(1'b0)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w[0]),
        .ecall_op(ecall_op), .ebreak_op(ebreak_op), .mret_op(mret_op), .sret_op(sret_op),
        .csrrw_op(csrrw_op), .csrrs_op(csrrs_op), .csrrc_op(csrrc_op), .illegal_op(illegal_op),
        .csr_addr(csr_addr), .insn(insn), .pc(pc),
        .out_valid(out_valid_w[0]), .out_ready(out_ready),
        .e_cause(e_cause_w[0]), .e_tval(e_tval_w[0]), .e_pc(e_pc_w[0]),
        .multi_err(multi_w[0]), .flush(flush_w[0]), .busy(busy_w[0])
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model of the transaction: waiting, result offered to commit, or flush window.
    int              m_mode  [2];
    int              m_left  [2];
    logic [4:0]      m_cause [2];
    logic [XLEN-1:0] m_tval  [2];
    logic [XLEN-1:0] m_pc    [2];
    logic            m_multi [2];

    function automatic logic [4:0] ref_cause(input int k);
        logic [7:0] s;
        int         codes [8];
        codes = '{8, 1, 2, 3, 4, 5, 6, 7};
        s = {illegal_op, ecall_op, ebreak_op, mret_op, sret_op, csrrw_op, csrrs_op, csrrc_op};
        if (k == 0 && sret_op) return 5'd8;
        for (int i = 0; i < 8; i++) begin
            if (k == 0 && i == 4) continue;
            if (s[7-i]) return 5'(codes[i]);
        end
        return 5'd0;
    endfunction

    function automatic logic [XLEN-1:0] ref_tval(input logic [4:0] c);
        if (c >= 5 && c <= 7) return XLEN'(csr_addr);
        if (c == 8)           return XLEN'(insn);
        if (c == 2)           return pc;
        return '0;
    endfunction

    always @(posedge clk or posedge rst) begin
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                m_mode[k] <= 0; m_left[k] <= 0; m_cause[k] <= '0;
                m_tval[k] <= '0; m_pc[k] <= '0; m_multi[k] <= 1'b0;
            end else if (m_mode[k] == 0) begin
                if (in_valid && (ref_cause(1) != 0)) begin
                    m_mode[k]  <= 1;
                    m_cause[k] <= ref_cause(k);
                    m_tval[k]  <= ref_tval(ref_cause(k));
                    m_pc[k]    <= pc;
                    m_multi[k] <= ($countones({illegal_op, ecall_op, ebreak_op, mret_op,
                                               sret_op, csrrw_op, csrrs_op, csrrc_op}) > 1);
                end
            end else if (m_mode[k] == 1) begin
                if (out_ready) begin
                    if (m_cause[k] >= 5 && m_cause[k] <= 7) begin
                        m_mode[k] <= 0; m_cause[k] <= '0; m_tval[k] <= '0;
                        m_pc[k] <= '0; m_multi[k] <= 1'b0;
                    end else begin
                        m_mode[k] <= 2; m_left[k] <= FC;
                    end
                end
            end else begin
                m_left[k] <= m_left[k] - 1;
                if (m_left[k] == 1) begin
                    m_mode[k] <= 0; m_cause[k] <= '0; m_tval[k] <= '0;
                    m_pc[k] <= '0; m_multi[k] <= 1'b0;
                end
            end
        end
    end

    // Every-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("in_ready[%0d]", k),  64'(in_ready_w[k]),  64'(m_mode[k] == 0));
            chk($sformatf("out_valid[%0d]", k), 64'(out_valid_w[k]), 64'(m_mode[k] == 1));
            chk($sformatf("flush[%0d]", k),     64'(flush_w[k]),     64'(m_mode[k] == 2));
            chk($sformatf("busy[%0d]", k),      64'(busy_w[k]),      64'(m_mode[k] != 0));
            chk($sformatf("e_cause[%0d]", k),   64'(e_cause_w[k]),   64'(m_cause[k]));
            chk($sformatf("e_tval[%0d]", k),    e_tval_w[k],         m_tval[k]);
            chk($sformatf("e_pc[%0d]", k),      e_pc_w[k],           m_pc[k]);
            chk($sformatf("multi_err[%0d]", k), 64'(multi_w[k]),     64'(m_multi[k]));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_ops();
        in_valid = 0; ecall_op = 0; ebreak_op = 0; mret_op = 0; sret_op = 0;
        csrrw_op = 0; csrrs_op = 0; csrrc_op = 0; illegal_op = 0;
    endtask

    task automatic wait_idle(input string nm);
        int n = 0;
        while (!(in_ready_w[1] && in_ready_w[0]) && n < 20) begin
            step();
            n++;
        end
        chk(nm, 64'(in_ready_w[1] && in_ready_w[0]), 64'd1);
    endtask

    task automatic commit();
        out_ready = 1;
        step();
        out_ready = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int fcnt;
        int lat;
        rst = 1;
        clr_ops();
        out_ready = 0; csr_addr = '0; insn = '0; pc = '0;
        step(); step();
        chk("reset in_ready",  64'(in_ready_w[1]),  64'd1);
        chk("reset out_valid", 64'(out_valid_w[1]), 64'd0);
        chk("reset e_cause",   64'(e_cause_w[1]),   64'd0);
        chk("reset flush",     64'(flush_w[1]),     64'd0);
        rst = 0;
        step();

        // CSR set op: no flush, ready one cycle after commit.
        in_valid = 1; csrrs_op = 1; csr_addr = 12'h300; pc = 64'h1000;
        step();
        clr_ops();
        chk("csr out_valid", 64'(out_valid_w[1]), 64'd1);
        chk("csr e_cause",   64'(e_cause_w[1]),   64'd6);
        chk("csr e_tval",    e_tval_w[1],         64'h300);
        chk("csr e_pc",      e_pc_w[1],           64'h1000);
        commit();
        chk("csr in_ready",  64'(in_ready_w[1]),  64'd1);
        chk("csr no flush",  64'(flush_w[1]),     64'd0);
        chk("csr cleared",   64'(e_cause_w[1]),   64'd0);

        // ebreak: tval = pc, flush exactly FC cycles.
        step();
        in_valid = 1; ebreak_op = 1; pc = 64'h8000_0040;
        step();
        clr_ops();
        chk("ebreak e_cause", 64'(e_cause_w[1]), 64'd2);
        chk("ebreak e_tval",  e_tval_w[1],       64'h8000_0040);
        commit();
        fcnt = 0; lat = 1;
        for (int i = 0; i < 10; i++) begin
            if (in_ready_w[1]) break;
            if (flush_w[1]) fcnt++;
            chk("ebreak hold cause", 64'(e_cause_w[1]), 64'd2);
            step();
            lat++;
        end
        chk("ebreak flush cycles", 64'(fcnt), 64'(FC));
        chk("ebreak ready latency", 64'(lat), 64'(FC + 1));
        chk("ebreak cleared", 64'(e_cause_w[1]), 64'd0);

        // illegal + ecall together.
        step();
        in_valid = 1; illegal_op = 1; ecall_op = 1; insn = 32'hDEAD_BEEF; pc = 64'h2000;
        step();
        clr_ops();
        chk("illegal e_cause", 64'(e_cause_w[1]), 64'd8);
        chk("illegal e_tval",  e_tval_w[1],       64'hDEAD_BEEF);
        chk("illegal multi",   64'(multi_w[1]),   64'd1);
        commit();
        wait_idle("illegal return");

        // sret with and without supervisor support.
        step();
        in_valid = 1; sret_op = 1; insn = 32'h1020_0073;
        step();
        clr_ops();
        chk("sret en e_cause",  64'(e_cause_w[1]), 64'd4);
        chk("sret en e_tval",   e_tval_w[1],       64'd0);
        chk("sret dis e_cause", 64'(e_cause_w[0]), 64'd8);
        chk("sret dis e_tval",  e_tval_w[0],       64'h1020_0073);
        commit();
        wait_idle("sret return");

        // Long HOLD with a competing op presented.
        step();
        in_valid = 1; csrrc_op = 1; csr_addr = 12'h341;
        step();
        csrrc_op = 0; csrrw_op = 1; csr_addr = 12'hFFF;
        for (int i = 0; i < 10; i++) begin
            chk("hold cause",    64'(e_cause_w[1]),  64'd7);
            chk("hold tval",     e_tval_w[1],        64'h341);
            chk("hold in_ready", 64'(in_ready_w[1]), 64'd0);
            step();
        end
        clr_ops();
        commit();
        chk("hold release", 64'(in_ready_w[1]), 64'd1);

        // in_valid without any strobe is ignored.
        in_valid = 1;
        step();
        in_valid = 0;
        chk("no-op ignored", 64'(out_valid_w[1]), 64'd0);

        // mret then back-to-back ecall attempt right at return.
        in_valid = 1; mret_op = 1;
        step();
        clr_ops();
        chk("mret e_cause", 64'(e_cause_w[1]), 64'd3);
        commit();
        in_valid = 1; csrrw_op = 1; csr_addr = 12'h7C0;
        wait_idle("mret return");
        step();
        clr_ops();
        chk("post-return capture", 64'(e_cause_w[1]), 64'd5);
        commit();

        // Reset during the first flush cycle.
        in_valid = 1; ecall_op = 1; pc = 64'h3000;
        step();
        clr_ops();
        commit();
        chk("pre-rst flush", 64'(flush_w[1]), 64'd1);
        rst = 1;
        #1;
        chk("rst flush",     64'(flush_w[1]),     64'd0);
        chk("rst out_valid", 64'(out_valid_w[1]), 64'd0);
        chk("rst busy",      64'(busy_w[1]),      64'd0);
        step();
        rst = 0;
        step();
        chk("post-rst in_ready", 64'(in_ready_w[1]), 64'd1);
        chk("post-rst e_cause",  64'(e_cause_w[1]),  64'd0);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/sysop_trap_seq.md
Name: sysop_trap_seq

Overview:
- Registered, parametrised successor to the combinational system-op cause/tval decode in the execute stage.
- Accepts one system op per handshake and priority-encodes it into a cause. Forms an XLEN-wide tval.
- Holds the result until commit accepts it, then runs a timed pipeline-flush sequence for trap-class ops.
- Sits between execute and the commit/CSR unit.

Parameters:
XLEN, 64, width of pc, tval and e_pc
FLUSH_CYCLES, 2, cycles flush is held after a trap-class op is accepted by commit; legal range >=1
SRET_EN, 1, 1: sret_op is a legal RET_S op; 0: sret_op is encoded as ILLEGAL

Ports:
clk  input  1  clock
rst  input  1  asynchronous, active-high reset
in_valid  input  1  execute presents an op
in_ready  output  1  block can capture an op
ecall_op/ebreak_op/mret_op/sret_op  input  1 each  system op strobes
csrrw_op/csrrs_op/csrrc_op  input  1 each  CSR op strobes
illegal_op  input  1  decode flagged illegal instruction
csr_addr  input  12  CSR address
insn  input  32  raw instruction word
pc  input  XLEN  pc of the op
out_valid  output  1  captured result valid
out_ready  input  1  commit accepts the result
e_cause  output  5  encoded cause
e_tval  output  XLEN  trap value
e_pc  output  XLEN  captured pc
multi_err  output  1  more than one op strobe was set at capture
flush  output  1  pipeline flush request
busy  output  1  state != IDLE

Behaviour:
- Reset is asynchronous and active-high. While it is asserted or after it releases:
  - state = IDLE
  - all outputs 0, except in_ready = 1 in IDLE
  - counter = 0
- Any op = OR of all 8 strobes.
- Cause codes, with priority highest first:
  - ILLEGAL = 8
  - ECALL = 1
  - EBREAK = 2
  - RET = 3 (mret)
  - RET_S = 4 (sret)
  - CSR_W = 5
  - CSR_S = 6
  - CSR_C = 7
  - NONE = 0
- If SRET_EN = 0, sret_op maps to ILLEGAL.
- tval by cause:
  - CSR_*: zero-extended csr_addr
  - ILLEGAL: zero-extended insn
  - EBREAK: pc
  - all others: 0
- multi_err = 1 when popcount(strobes) > 1. The priority winner is still reported.
- State IDLE:
  - in_ready = 1.
  - If in_valid and any op: capture e_cause, e_tval, e_pc and multi_err on this edge, then go to HOLD.
  - If in_valid with no op: ignore, stay in IDLE.
- State HOLD:
  - out_valid = 1 and in_ready = 0.
  - Captured outputs stay stable until out_ready.
  - On out_ready with cause in {ILLEGAL, ECALL, EBREAK, RET, RET_S}: go to FLUSH, load counter = FLUSH_CYCLES.
  - On out_ready with a CSR cause: go to IDLE.
  - out_valid drops on the next cycle.
- State FLUSH:
  - flush = 1 and in_ready = 0.
  - The counter decrements each cycle. On the cycle it would reach 0, go to IDLE.
  - flush is therefore high for exactly FLUSH_CYCLES cycles.
  - e_* outputs hold their values through FLUSH.
- Returning to IDLE:
  - e_cause, e_tval, e_pc and multi_err clear to 0 on entry to IDLE.
  - There is no back-to-back capture in the same cycle as the HOLD or FLUSH exit. The next capture occurs at the earliest one cycle after re-entering IDLE.
- Latency:
  - capture edge -> out_valid: 1 cycle
  - CSR op: out_ready edge -> in_ready: 1 cycle
  - trap op: out_ready edge -> in_ready: FLUSH_CYCLES + 1 cycles
- in_valid or strobes changing while not in IDLE have no effect.
- Reset mid-HOLD or mid-FLUSH aborts immediately and drops flush asynchronously.

Decomposition:
- Shared package sysop_pkg holds:
  - the 5-bit SYSOP_* cause constants listed above
  - the state enum {IDLE, HOLD, FLUSH}
  - a helper function for the trap-class predicate
- One natural sub-module: sysop_prio_enc. It is combinational and computes strobes -> cause, tval, multi_err, and is parametrised by XLEN and SRET_EN.
- The FSM and the capture registers live in the top-level module.

Test Plan:
- csrrs_op = 1, csr_addr = 12'h300, in_valid pulse -> next cycle out_valid = 1, e_cause = 6, e_tval = 64'h300. After out_ready: flush never asserts, in_ready = 1 one cycle later.
- ebreak_op = 1, pc = 64'h8000_0040 -> e_cause = 2, e_tval = 64'h8000_0040. After out_ready: flush high exactly 2 cycles, then in_ready = 1.
- illegal_op + ecall_op together, insn = 32'hDEAD_BEEF -> e_cause = 8, e_tval = 64'hDEAD_BEEF, multi_err = 1.
- SRET_EN = 0, sret_op = 1 -> e_cause = 8. SRET_EN = 1, sret_op = 1 -> e_cause = 4, e_tval = 0.
- HOLD with out_ready low for 10 cycles while a new csrrw_op is driven -> outputs unchanged, in_ready = 0, new op not captured.
- rst asserted during the first FLUSH cycle -> flush, out_valid and busy go to 0 immediately; after release in_ready = 1 and e_cause = 0.
